// File: rtl/alu_writeback_queue.sv
// alu_writeback_queue
//   In-order result queue between the execute-stage ALU and the register-file
//   write port. ALU results are captured in a small FIFO and drained under a
//   valid/ready handshake, so ALU issue is decoupled from write-port contention.
//   Writes to register zero complete the handshake but are never stored.
//
//   Optional feature macro: WB_FORWARD_EN
//     defined   -> combinational lookup of the youngest queued entry whose
//                  destination matches fwd_addr (operand forwarding)
//     undefined -> fwd_hit / fwd_data tied to zero, fwd_addr ignored

module alu_writeback_queue #(
    parameter int N          = 32,
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_result,
    input  logic                    in_carry,
    input  logic [REG_ADDR_W-1:0]   in_rd,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [N-1:0]            wb_data,
    output logic                    wb_carry,
    output logic [REG_ADDR_W-1:0]   wb_addr,
    output logic [$clog2(DEPTH):0]  count,
    input  logic [REG_ADDR_W-1:0]   fwd_addr,
    output logic                    fwd_hit,
    output logic [N-1:0]            fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [N-1:0]          dataMem_q  [DEPTH];
    logic                  carryMem_q [DEPTH];
    logic [REG_ADDR_W-1:0] addrMem_q  [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic store;

    // Full blocks pushes even if a pop happens in the same cycle, so in_ready
    // depends on the registered count alone and never on wb_ready.
    assign in_ready = (count_q < CNT_W'(DEPTH));
    assign wb_valid = (count_q != '0);
    assign count    = count_q;

    assign push  = in_valid & in_ready;
    assign pop   = wb_valid & wb_ready;
    assign store = push & (in_rd != '0);

    // Next-state for pointers and occupancy; flush wipes the queue and voids
    // any same-cycle push or pop.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (store) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(store) - CNT_W'(pop);
        end
    end

    // Pointer and occupancy registers; reset overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage is written only on an accepted, non-dropped push.
    always_ff @(posedge clk) begin
        if (store && !flush && !rst) begin
            dataMem_q[wrPtr_q]  <= in_result;
            carryMem_q[wrPtr_q] <= in_carry;
            addrMem_q[wrPtr_q]  <= in_rd;
        end
    end

    // Head entry drives the write port; outputs read as zero when empty.
    always_comb begin
        wb_data  = '0;
        wb_carry = 1'b0;
        wb_addr  = '0;
        if (wb_valid) begin
            wb_data  = dataMem_q[rdPtr_q];
            wb_carry = carryMem_q[rdPtr_q];
            wb_addr  = addrMem_q[rdPtr_q];
        end
    end

`ifdef WB_FORWARD_EN
    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (fwd_addr != '0) &&
                (addrMem_q[rdPtr_q + PTR_W'(i)] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = dataMem_q[rdPtr_q + PTR_W'(i)];
            end
        end
    end
`else
    logic fwdAddr_unused;
    assign fwdAddr_unused = ^fwd_addr;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_queue.sv
// tb_alu_writeback_queue
//   Directed-vector bench for alu_writeback_queue with hand-computed
//   expectations. Honours WB_FORWARD_EN for the forwarding expectations.

module tb_alu_writeback_queue;

   localparam int N  = 32;
   localparam int RW = 4;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          rst, flush, inValid, inReady, inCarry;
   logic [N-1:0]  inResult;
   logic [RW-1:0] inRd;
   logic          wbValid, wbReady, wbCarry;
   logic [N-1:0]  wbData;
   logic [RW-1:0] wbAddr;
   logic [2:0]    count;
   logic [RW-1:0] fwdAddr;
   logic          fwdHit;
   logic [N-1:0]  fwdData;

   int testsRun    = 0;
   int testsFailed = 0;

`ifdef WB_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   alu_writeback_queue #(.N(N), .REG_ADDR_W(RW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(inValid), .in_ready(inReady), .in_result(inResult),
      .in_carry(inCarry), .in_rd(inRd),
      .wb_valid(wbValid), .wb_ready(wbReady), .wb_data(wbData),
      .wb_carry(wbCarry), .wb_addr(wbAddr), .count(count),
      .fwd_addr(fwdAddr), .fwd_hit(fwdHit), .fwd_data(fwdData)
   );

   always #5 clk = ~clk;

   // One comparison: counts it and reports a mismatch with both values.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one ALU result on the input side (held until changed).
   task automatic applyStimulus(input logic v, input logic [N-1:0] res, input logic c, input logic [RW-1:0] rd);
      inValid  = v;
      inResult = res;
      inCarry  = c;
      inRd     = rd;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_wbValid"}, 64'(wbValid), 64'd0);
      checkOutput({tag, "_wbData"},  64'(wbData),  64'd0);
      checkOutput({tag, "_wbCarry"}, 64'(wbCarry), 64'd0);
      checkOutput({tag, "_wbAddr"},  64'(wbAddr),  64'd0);
      checkOutput({tag, "_inReady"}, 64'(inReady), 64'd1);
      checkOutput({tag, "_count"},   64'(count),   64'd0);
      checkOutput({tag, "_fwdHit"},  64'(fwdHit),  64'd0);
      checkOutput({tag, "_fwdData"}, 64'(fwdData), 64'd0);
   endtask

   logic [N-1:0]  expData[$];
   logic [RW-1:0] expRd[$];

   initial begin
      rst = 1'b1; flush = 1'b0; wbReady = 1'b0; fwdAddr = '0;
      applyStimulus(1'b0, '0, 1'b0, '0);
      #1;
      step(); step();
      rst = 1'b0;
      checkReset("reset");

      // Single entry round trip
      wbReady = 1'b1;
      applyStimulus(1'b1, 32'h5, 1'b0, 4'd3);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("t1_wbValid", 64'(wbValid), 64'd1);
      checkOutput("t1_wbData",  64'(wbData),  64'd5);
      checkOutput("t1_wbAddr",  64'(wbAddr),  64'd3);
      checkOutput("t1_count",   64'(count),   64'd1);
      step();
      checkOutput("t1_countAfter", 64'(count),   64'd0);
      checkOutput("t1_emptyValid", 64'(wbValid), 64'd0);

      // Fill, refused push, no push-through when full, ordered drain
      wbReady = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1'b1, 32'h100 + 32'(k), k[0], RW'(k));
         step();
      end
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("t2_countFull",  64'(count),   64'd4);
      checkOutput("t2_inReady",    64'(inReady), 64'd0);
      checkOutput("t2_headAddr",   64'(wbAddr),  64'd1);
      applyStimulus(1'b1, 32'hDEAD, 1'b1, 4'd5);
      step();
      checkOutput("t2_refusedCnt", 64'(count),   64'd4);
      checkOutput("t2_refusedHd",  64'(wbData),  64'h101);
      wbReady = 1'b1;
      applyStimulus(1'b1, 32'hBEEF, 1'b0, 4'd6);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("t2_noPassCnt",  64'(count),   64'd3);
      for (int k = 2; k <= 4; k++) begin
         checkOutput($sformatf("t2_drainAddr%0d", k),  64'(wbAddr),  64'(k));
         checkOutput($sformatf("t2_drainData%0d", k),  64'(wbData),  64'h100 + 64'(k));
         checkOutput($sformatf("t2_drainCarry%0d", k), 64'(wbCarry), 64'(k % 2));
         step();
      end
      checkOutput("t2_drained", 64'(wbValid), 64'd0);

      // Steady state with count=2 and simultaneous push/pop (pointers wrap)
      wbReady = 1'b0;
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 32'h200 + 32'(k), 1'b0, RW'(k + 1));
         expData.push_back(32'h200 + 32'(k));
         expRd.push_back(RW'(k + 1));
         step();
      end
      wbReady = 1'b1;
      for (int j = 0; j < 10; j++) begin
         applyStimulus(1'b1, 32'h300 + 32'(j), 1'b0, RW'((j % 15) + 1));
         checkOutput($sformatf("t3_count%0d", j), 64'(count),  64'd2);
         checkOutput($sformatf("t3_data%0d", j),  64'(wbData), 64'(expData[0]));
         checkOutput($sformatf("t3_addr%0d", j),  64'(wbAddr), 64'(expRd[0]));
         void'(expData.pop_front());
         void'(expRd.pop_front());
         expData.push_back(32'h300 + 32'(j));
         expRd.push_back(RW'((j % 15) + 1));
         step();
      end
      applyStimulus(1'b0, '0, 1'b0, '0);
      for (int j = 0; j < 2; j++) begin
         checkOutput($sformatf("t3_tailData%0d", j), 64'(wbData), 64'(expData[0]));
         void'(expData.pop_front());
         step();
      end
      checkOutput("t3_empty", 64'(count), 64'd0);

      // Register zero push completes but is not stored
      wbReady = 1'b0;
      applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 4'd0);
      checkOutput("t4_inReady", 64'(inReady), 64'd1);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("t4_count",   64'(count),   64'd0);
      checkOutput("t4_wbValid", 64'(wbValid), 64'd0);
      checkOutput("t4_wbData",  64'(wbData),  64'd0);

      // Flush with same-cycle push and pop
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 32'h400 + 32'(k), 1'b0, RW'(k));
         step();
      end
      checkOutput("t5_countPre", 64'(count), 64'd3);
      flush = 1'b1; wbReady = 1'b1;
      applyStimulus(1'b1, 32'h999, 1'b1, 4'd9);
      step();
      flush = 1'b0; wbReady = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("t5_flushCount", 64'(count),   64'd0);
      checkOutput("t5_flushValid", 64'(wbValid), 64'd0);
      step();
      checkOutput("t5_flushStays", 64'(count),   64'd0);

      // Reset in the middle of a drain
      for (int k = 1; k <= 3; k++) begin
         applyStimulus(1'b1, 32'h500 + 32'(k), 1'b1, RW'(k + 8));
         step();
      end
      applyStimulus(1'b0, '0, 1'b0, '0);
      wbReady = 1'b1;
      step();
      checkOutput("t5_midDrain", 64'(wbAddr), 64'd10);
      rst = 1'b1;
      applyStimulus(1'b1, 32'h777, 1'b1, 4'd2);
      step();
      rst = 1'b0; wbReady = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkReset("t5_rst");

      // Forwarding lookup: youngest match wins, rd zero never hits
      applyStimulus(1'b1, 32'h11, 1'b0, 4'd7); step();
      applyStimulus(1'b1, 32'h22, 1'b0, 4'd7); step();
      applyStimulus(1'b1, 32'h33, 1'b0, 4'd5); step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      fwdAddr = 4'd7; #1;
      checkOutput("t6_hit7",  64'(fwdHit),  64'(FWD));
      checkOutput("t6_data7", 64'(fwdData), FWD ? 64'h22 : 64'h0);
      fwdAddr = 4'd5; #1;
      checkOutput("t6_data5", 64'(fwdData), FWD ? 64'h33 : 64'h0);
      fwdAddr = 4'd0; #1;
      checkOutput("t6_hit0",  64'(fwdHit),  64'd0);
      fwdAddr = 4'd9;
      applyStimulus(1'b1, 32'h44, 1'b0, 4'd9); #1;
      checkOutput("t6_samePush", 64'(fwdHit), 64'd0);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0);
      checkOutput("t6_afterPush", 64'(fwdHit),  64'(FWD));
      checkOutput("t6_count",     64'(count),   64'd4);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
